iir_cascade: RTL and testbench

Parametrised, time-multiplexed cascade of N_SECTIONS direct-form-I biquad IIR sections sharing one multiplier-accumulator. It sits between the audio input deserialiser and the DSP mixer and replaces the single fixed biquad band filter. Coefficients are runtime-writable per section, and the block supports bypass, history clear, saturation instead of bit truncation, and overrun reporting.

---
 rtl/iir_cascade_pkg.sv | 36 +++
 rtl/iir_cascade_coef.sv | 38 +++
 rtl/iir_cascade.sv | 187 ++++++++++++++++++
 tb/tb_iir_cascade.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iir_cascade_pkg.sv
// Shared types, tap numbering and helpers for the time-multiplexed biquad cascade.
// Saturation helper works on 64-bit signed values so any width up to 64 can be clamped.
package iir_cascade_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        WB   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [2:0] TAP_B1 = 3'd0;
    localparam logic [2:0] TAP_B2 = 3'd1;
    localparam logic [2:0] TAP_B3 = 3'd2;
    localparam logic [2:0] TAP_A2 = 3'd3;
    localparam logic [2:0] TAP_A3 = 3'd4;
    localparam int         NUM_TAPS = 5;

    // Pass-through reset value: b1 = 1.0 in the coefficient's Q format, all other taps 0.
    function automatic longint coef_reset_val(input int tap, input int frac);
        return (tap == int'(TAP_B1)) ? (64'sd1 <<< frac) : 64'sd0;
    endfunction

    function automatic logic signed [63:0] sat_s(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        return v;
    endfunction

endpackage

// File: rtl/iir_cascade_coef.sv
// Runtime-writable coefficient register file, 5 taps per section, reset to pass-through.
// Read is combinational by (section, tap) so the MAC sees the value stored before any same-cycle write.
module iir_coef_bank
    import iir_cascade_pkg::*;
#(
    parameter int N_SECTIONS = 2,
    parameter int COEF_W     = 18,
    parameter int COEF_FRAC  = 16,
    parameter int SEC_W      = 1,
    parameter int ADDR_W     = $clog2(5*N_SECTIONS)
) (
    input  logic                     clk,
    input  logic                     i_rst,
    input  logic                     i_we,
    input  logic [ADDR_W-1:0]        i_addr,
    input  logic [COEF_W-1:0]        i_wdata,
    input  logic [SEC_W-1:0]         i_sec,
    input  logic [2:0]               i_tap,
    output logic signed [COEF_W-1:0] o_coef
);
    localparam int NUM_COEF = NUM_TAPS * N_SECTIONS;

    logic [NUM_COEF-1:0][COEF_W-1:0] r_coef;
    logic [ADDR_W-1:0]               w_idx;

    assign w_idx  = ADDR_W'(i_sec) * ADDR_W'(NUM_TAPS) + ADDR_W'(i_tap);
    assign o_coef = r_coef[w_idx];

    always_ff @(posedge clk) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_COEF; i++)
                r_coef[i] <= COEF_W'(coef_reset_val(i % NUM_TAPS, COEF_FRAC));
        end else if (i_we && (int'(i_addr) < NUM_COEF)) begin
            r_coef[i_addr] <= i_wdata;
        end
    end

endmodule

// File: rtl/iir_cascade.sv
// Cascade of direct-form-I biquads sharing one MAC: 5 MAC cycles plus one writeback per section.
// Rounds half-up, saturates each section to STATE_W and the final output to DATA_W.
module iir_cascade
    import iir_cascade_pkg::*;
#(
    parameter int N_SECTIONS = 2,
    parameter int DATA_W     = 16,
    parameter int COEF_W     = 18,
    parameter int COEF_FRAC  = 16,
    parameter int STATE_W    = 21
) (
    input  logic                              clk,
    input  logic                              i_rst,
    input  logic                              i_valid,
    input  logic [DATA_W-1:0]                 i_sample,
    input  logic                              i_bypass,
    input  logic                              i_clear,
    input  logic                              i_coef_we,
    input  logic [$clog2(5*N_SECTIONS)-1:0]   i_coef_addr,
    input  logic [COEF_W-1:0]                 i_coef_data,
    output logic                              o_busy,
    output logic                              o_valid,
    output logic [DATA_W-1:0]                 o_sample,
    output logic                              o_overrun,
    output logic                              o_sat
);
    localparam int ADDR_W = $clog2(5*N_SECTIONS);
    localparam int SEC_W  = (N_SECTIONS > 1) ? $clog2(N_SECTIONS) : 1;
    localparam int PROD_W = STATE_W + COEF_W;
    localparam int ACC_W  = STATE_W + COEF_W + 3;

    state_t r_state, w_next;

    logic [SEC_W-1:0]                     r_sec;
    logic [2:0]                           r_tap;
    logic signed [ACC_W-1:0]              r_acc;
    logic signed [STATE_W-1:0]            r_xin;
    logic [DATA_W-1:0]                    r_sample_in;
    logic                                 r_bypass;
    logic [N_SECTIONS-1:0][STATE_W-1:0]   r_x1, r_x2, r_y1, r_y2;
    logic                                 r_valid, r_overrun, r_sat;
    logic [DATA_W-1:0]                    r_sample;

    logic signed [COEF_W-1:0]  w_coef;
    logic signed [STATE_W-1:0] w_op;
    logic signed [PROD_W-1:0]  w_prod;
    logic signed [ACC_W-1:0]   w_prod_ext, w_acc_next;
    logic signed [63:0]        w_round, w_shift, w_y64, w_y_ext, w_out64;
    logic signed [STATE_W-1:0] w_y;
    logic                      w_ysat, w_osat, w_last;

    iir_coef_bank #(
        .N_SECTIONS(N_SECTIONS),
        .COEF_W    (COEF_W),
        .COEF_FRAC (COEF_FRAC),
        .SEC_W     (SEC_W),
        .ADDR_W    (ADDR_W)
    ) u_coef (
        .clk    (clk),
        .i_rst  (i_rst),
        .i_we   (i_coef_we),
        .i_addr (i_coef_addr),
        .i_wdata(i_coef_data),
        .i_sec  (r_sec),
        .i_tap  (r_tap),
        .o_coef (w_coef)
    );

    assign w_last = (r_sec == SEC_W'(N_SECTIONS - 1));

    always_comb begin
        w_op = '0;
        case (r_tap)
            TAP_B1:  w_op = r_xin;
            TAP_B2:  w_op = r_x1[r_sec];
            TAP_B3:  w_op = r_x2[r_sec];
            TAP_A2:  w_op = r_y1[r_sec];
            TAP_A3:  w_op = r_y2[r_sec];
            default: w_op = '0;
        endcase
    end

    // Feedback taps are subtracted so stored a2/a3 keep their textbook sign.
    assign w_prod     = w_op * w_coef;
    assign w_prod_ext = {{3{w_prod[PROD_W-1]}}, w_prod};
    assign w_acc_next = (r_tap >= TAP_A2) ? (r_acc - w_prod_ext) : (r_acc + w_prod_ext);

    assign w_round = {{(64-ACC_W){r_acc[ACC_W-1]}}, r_acc} + (64'sd1 <<< (COEF_FRAC - 1));
    assign w_shift = w_round >>> COEF_FRAC;
    assign w_y64   = sat_s(w_shift, STATE_W);
    assign w_ysat  = (w_y64 != w_shift);
    assign w_y     = w_y64[STATE_W-1:0];
    assign w_y_ext = {{(64-STATE_W){w_y[STATE_W-1]}}, w_y};
    assign w_out64 = sat_s(w_y_ext, DATA_W);
    assign w_osat  = (w_out64 != w_y_ext);

    always_ff @(posedge clk) begin
        if (i_rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_valid) w_next = MAC;
            MAC:     if (r_tap == TAP_A3) w_next = WB;
            WB:      w_next = w_last ? DONE : MAC;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_sec       <= '0;
            r_tap       <= '0;
            r_acc       <= '0;
            r_xin       <= '0;
            r_sample_in <= '0;
            r_bypass    <= 1'b0;
            r_x1        <= '0;
            r_x2        <= '0;
            r_y1        <= '0;
            r_y2        <= '0;
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
            r_sat       <= 1'b0;
            r_sample    <= '0;
        end else begin
            r_valid   <= 1'b0;
            r_overrun <= i_valid && (r_state != IDLE);
            case (r_state)
                IDLE: begin
                    if (i_valid) begin
                        r_acc       <= '0;
                        r_sec       <= '0;
                        r_tap       <= '0;
                        r_xin       <= {{(STATE_W-DATA_W){i_sample[DATA_W-1]}}, i_sample};
                        r_sample_in <= i_sample;
                        r_bypass    <= i_bypass;
                    end
                end
                MAC: begin
                    r_acc <= w_acc_next;
                    r_tap <= (r_tap == TAP_A3) ? 3'd0 : r_tap + 3'd1;
                end
                WB: begin
                    r_acc <= '0;
                    r_tap <= '0;
                    r_xin <= w_y;
                    if (!r_bypass) begin
                        r_x2[r_sec] <= r_x1[r_sec];
                        r_x1[r_sec] <= r_xin;
                        r_y2[r_sec] <= r_y1[r_sec];
                        r_y1[r_sec] <= w_y;
                        if (w_ysat || (w_last && w_osat))
                            r_sat <= 1'b1;
                    end
                    if (w_last) begin
                        r_valid  <= 1'b1;
                        r_sample <= r_bypass ? r_sample_in : w_out64[DATA_W-1:0];
                    end else begin
                        r_sec <= r_sec + SEC_W'(1);
                    end
                end
                default: ;
            endcase
            // Clear overrides any same-cycle history shift or saturation flag.
            if (i_clear) begin
                r_x1  <= '0;
                r_x2  <= '0;
                r_y1  <= '0;
                r_y2  <= '0;
                r_sat <= 1'b0;
            end
        end
    end

    assign o_busy    = (r_state != IDLE);
    assign o_valid   = r_valid;
    assign o_sample  = r_sample;
    assign o_overrun = r_overrun;
    assign o_sat     = r_sat;

endmodule

// File: tb/tb_iir_cascade.sv
// Self-checking bench for iir_cascade: directed vectors plus randomized samples/coefficients
// compared against a floating-free integer biquad model of the cascade.
module tb_iir_cascade;
    localparam int N  = 2;
    localparam int DW = 16;
    localparam int CW = 18;
    localparam int CF = 16;
    localparam int SW = 21;
    localparam int AW = $clog2(5*N);
    localparam int LAT = 6*N + 1;

    logic          clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_valid = 1'b0;
    logic [DW-1:0] i_sample = '0;
    logic          i_bypass = 1'b0;
    logic          i_clear = 1'b0;
    logic          i_coef_we = 1'b0;
    logic [AW-1:0] i_coef_addr = '0;
    logic [CW-1:0] i_coef_data = '0;
    logic          o_busy, o_valid, o_overrun, o_sat;
    logic [DW-1:0] o_sample;

    always #5 clk = ~clk;

    iir_cascade #(.N_SECTIONS(N), .DATA_W(DW), .COEF_W(CW), .COEF_FRAC(CF), .STATE_W(SW)) dut (
        .clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_sample(i_sample), .i_bypass(i_bypass),
        .i_clear(i_clear), .i_coef_we(i_coef_we), .i_coef_addr(i_coef_addr), .i_coef_data(i_coef_data),
        .o_busy(o_busy), .o_valid(o_valid), .o_sample(o_sample), .o_overrun(o_overrun), .o_sat(o_sat)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_ovr = 0;

    always @(negedge clk) if (o_overrun === 1'b1) n_ovr++;

    // Reference model: coefficients, per-section history and sticky saturation flag.
    longint mc [N][5];
    longint mx1[N], mx2[N], my1[N], my2[N];
    bit     msat;

    function automatic longint clampw(input longint v, input int w, inout bit s);
        longint hi, lo;
        hi = (64'sd1 <<< (w-1)) - 1;
        lo = -(64'sd1 <<< (w-1));
        if (v > hi) begin s = 1'b1; return hi; end
        if (v < lo) begin s = 1'b1; return lo; end
        return v;
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < N; s++) begin
            for (int t = 0; t < 5; t++) mc[s][t] = (t == 0) ? 65536 : 0;
            mx1[s] = 0; mx2[s] = 0; my1[s] = 0; my2[s] = 0;
        end
        msat = 1'b0;
    endfunction

    function automatic void model_clear();
        for (int s = 0; s < N; s++) begin
            mx1[s] = 0; mx2[s] = 0; my1[s] = 0; my2[s] = 0;
        end
        msat = 1'b0;
    endfunction

    function automatic longint model_step(input longint smp, input bit byp);
        longint x, acc, y;
        bit     s;
        if (byp) return smp;
        s = 1'b0;
        x = smp;
        for (int i = 0; i < N; i++) begin
            acc = mc[i][0]*x + mc[i][1]*mx1[i] + mc[i][2]*mx2[i] - mc[i][3]*my1[i] - mc[i][4]*my2[i];
            y = clampw((acc + (64'sd1 <<< (CF-1))) >>> CF, SW, s);
            mx2[i] = mx1[i]; mx1[i] = x; my2[i] = my1[i]; my1[i] = y;
            x = y;
        end
        x = clampw(x, DW, s);
        if (s) msat = 1'b1;
        return x;
    endfunction

    task automatic coef_write_raw(input int addr, input longint val);
        @(negedge clk);
        i_coef_we = 1'b1; i_coef_addr = AW'(addr); i_coef_data = val[CW-1:0];
        @(negedge clk);
        i_coef_we = 1'b0;
        if (addr < 5*N) mc[addr/5][addr%5] = val;
    endtask

    task automatic coef_write(input int sec, input int tap, input longint val);
        coef_write_raw(sec*5 + tap, val);
    endtask

    task automatic pulse_clear();
        @(negedge clk); i_clear = 1'b1;
        @(negedge clk); i_clear = 1'b0;
        model_clear();
    endtask

    // Called at a negedge; returns one negedge later (cycle T+1).
    task automatic send(input longint smp, input bit byp);
        i_valid = 1'b1; i_sample = smp[DW-1:0]; i_bypass = byp;
        @(negedge clk);
        i_valid = 1'b0; i_bypass = 1'b0;
    endtask

    task automatic wait_out(input int start, output int lat);
        lat = start;
        while (o_valid !== 1'b1 && lat < 60) begin
            @(negedge clk); lat++;
        end
        if (o_valid !== 1'b1) lat = -1;
    endtask

    task automatic run_sample(input longint smp, input bit byp, output int lat, output longint got);
        @(negedge clk);
        send(smp, byp);
        wait_out(1, lat);
        got = longint'($signed(o_sample));
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (2) @(negedge clk);
        i_rst = 1'b0;
        model_reset();
        n_cmp++;
        if ({o_valid, o_busy, o_overrun, o_sat, o_sample} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got v=%b b=%b ov=%b sat=%b smp=%0d required all 0",
                     o_valid, o_busy, o_overrun, o_sat, o_sample);
        end
    endtask

    task automatic test_passthrough();
        int lat; longint got, exp;
        run_sample(1000, 0, lat, got);
        exp = model_step(1000, 0);
        n_cmp++;
        if (lat != LAT) begin n_bad++; $display("FAIL pass_latency: got %0d required %0d", lat, LAT); end
        n_cmp++;
        if (got !== 1000 || exp != 1000) begin n_bad++; $display("FAIL pass_value: got %0d required 1000", got); end
        n_cmp++;
        if (o_sat !== 1'b0) begin n_bad++; $display("FAIL pass_sat: got %b required 0", o_sat); end
    endtask

    task automatic test_gain();
        int lat; longint got, exp;
        coef_write(0, 0, 32768);
        run_sample(1000, 0, lat, got);
        exp = model_step(1000, 0);
        n_cmp++;
        if (got !== 500) begin n_bad++; $display("FAIL gain_pos: got %0d required 500 (model %0d)", got, exp); end
        run_sample(-1001, 0, lat, got);
        exp = model_step(-1001, 0);
        n_cmp++;
        if (got !== -500) begin n_bad++; $display("FAIL gain_neg_round: got %0d required -500 (model %0d)", got, exp); end
    endtask

    task automatic test_saturation();
        int lat; longint got, exp;
        coef_write(0, 0, 131071);
        coef_write(1, 0, 131071);
        run_sample(30000, 0, lat, got);
        exp = model_step(30000, 0);
        n_cmp++;
        if (got !== 32767) begin n_bad++; $display("FAIL sat_value: got %0d required 32767 (model %0d)", got, exp); end
        n_cmp++;
        if (o_sat !== 1'b1) begin n_bad++; $display("FAIL sat_flag: got %b required 1", o_sat); end
        pulse_clear();
        n_cmp++;
        if (o_sat !== 1'b0) begin n_bad++; $display("FAIL sat_clear: got %b required 0", o_sat); end
    endtask

    task automatic test_pole();
        int lat; longint got, exp;
        longint req[4] = '{16384, 8192, 4096, 2048};
        coef_write(0, 0, 65536);
        coef_write(1, 0, 65536);
        coef_write(0, 3, -32768);
        for (int k = 0; k < 4; k++) begin
            run_sample((k == 0) ? 16384 : 0, 0, lat, got);
            exp = model_step((k == 0) ? 16384 : 0, 0);
            n_cmp++;
            if (got !== req[k]) begin
                n_bad++; $display("FAIL pole_step%0d: got %0d required %0d (model %0d)", k, got, req[k], exp);
            end
        end
        pulse_clear();
        run_sample(0, 0, lat, got);
        exp = model_step(0, 0);
        n_cmp++;
        if (got !== 0) begin n_bad++; $display("FAIL pole_after_clear: got %0d required 0", got); end
    endtask

    task automatic test_overrun_bypass();
        int lat; longint got, exp;
        @(negedge clk);
        send(16384, 0);
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (o_busy !== 1'b1) begin n_bad++; $display("FAIL busy_mid: got %b required 1", o_busy); end
        i_valid = 1'b1; i_sample = DW'(7777);
        @(negedge clk);
        i_valid = 1'b0;
        n_cmp++;
        if (o_overrun !== 1'b1) begin n_bad++; $display("FAIL overrun_pulse: got %b required 1", o_overrun); end
        @(negedge clk);
        n_cmp++;
        if (o_overrun !== 1'b0) begin n_bad++; $display("FAIL overrun_width: got %b required 0", o_overrun); end
        wait_out(5, lat);
        got = longint'($signed(o_sample));
        exp = model_step(16384, 0);
        n_cmp++;
        if (lat != LAT || got !== 16384) begin
            n_bad++; $display("FAIL overrun_inflight: got %0d at lat %0d required 16384 at %0d", got, lat, LAT);
        end
        run_sample(-123, 1, lat, got);
        exp = model_step(-123, 1);
        n_cmp++;
        if (lat != LAT || got !== -123) begin
            n_bad++; $display("FAIL bypass: got %0d at lat %0d required -123 at %0d", got, lat, LAT);
        end
        run_sample(0, 0, lat, got);
        exp = model_step(0, 0);
        n_cmp++;
        if (got !== exp || got !== 8192) begin
            n_bad++; $display("FAIL bypass_history: got %0d required 8192 (model %0d)", got, exp);
        end
    endtask

    task automatic test_back_to_back();
        int lat, ovr0, nbad0; longint got, exp, smp; bit byp;
        longint v;
        for (int s = 0; s < N; s++)
            for (int t = 0; t < 5; t++) begin
                v = (t < 3) ? longint'($urandom_range(0, 80000)) - 40000
                            : longint'($urandom_range(0, 40000)) - 20000;
                coef_write(s, t, v);
            end
        coef_write_raw(5*N, 131071);
        ovr0 = n_ovr;
        nbad0 = n_bad;
        for (int k = 0; k < 16; k++) begin
            smp = longint'($urandom_range(0, 65535)) - 32768;
            byp = ($urandom_range(0, 5) == 0);
            run_sample(smp, byp, lat, got);
            exp = model_step(smp, byp);
            n_cmp++;
            if (lat != LAT || got !== exp) begin
                n_bad++;
                $display("FAIL rand_%0d: in %0d byp %0b got %0d at lat %0d required %0d at %0d",
                         k, smp, byp, got, lat, exp, LAT);
            end
        end
        n_cmp++;
        if (o_sat !== msat) begin n_bad++; $display("FAIL rand_sat: got %b required %b", o_sat, msat); end
        n_cmp++;
        if (n_ovr != ovr0) begin n_bad++; $display("FAIL b2b_overrun: got %0d pulses required 0", n_ovr - ovr0); end
        if (n_bad != nbad0) $display("note: random phase had %0d mismatches", n_bad - nbad0);
    endtask

    task automatic test_reset_mid();
        int lat, seen; longint got, exp;
        coef_write(0, 0, 32768);
        @(negedge clk);
        send(1234, 0);
        repeat (4) @(negedge clk);
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        model_reset();
        n_cmp++;
        if ({o_valid, o_busy, o_overrun, o_sat, o_sample} !== '0) begin
            n_bad++;
            $display("FAIL midreset_outputs: got v=%b b=%b ov=%b sat=%b smp=%0d required all 0",
                     o_valid, o_busy, o_overrun, o_sat, o_sample);
        end
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (o_valid === 1'b1) seen++;
        end
        n_cmp++;
        if (seen != 0) begin n_bad++; $display("FAIL midreset_no_valid: got %0d pulses required 0", seen); end
        run_sample(1000, 0, lat, got);
        exp = model_step(1000, 0);
        n_cmp++;
        if (lat != LAT || got !== 1000) begin
            n_bad++; $display("FAIL midreset_coefs: got %0d at lat %0d required 1000 at %0d (model %0d)",
                              got, lat, LAT, exp);
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_gain();
        test_saturation();
        test_pole();
        test_overrun_bypass();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
